// File: rtl/data_io_pkg.sv
// Shared byte-lane definitions for the data input decoder and output encoder.
// Lane select encoding: 0 -> [7:0] .. NUM_BYTES-1 -> most significant byte.
package data_io_pkg;

   localparam int BYTE_W    = 8;
   localparam int NUM_BYTES = 4;
   localparam int SEL_W     = $clog2(NUM_BYTES);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } xfer_state_t;

endpackage

// File: rtl/word_skid_buffer.sv
// One-entry pending register with valid/ready handshakes on both sides.
// Lets a producer hand over the next word while the current one is still draining.
module word_skid_buffer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic full;

   assign in_ready  = !full;
   assign out_valid = full;

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
      end else if (in_valid && in_ready) begin
         full <= 1'b1;
      end else if (out_valid && out_ready) begin
         full <= 1'b0;
      end
   end

   // NOTE: the payload register has no reset; the full flag alone says whether it holds a word.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         out_data <= in_data;
      end
   end

endmodule

// File: rtl/data_out_encoder.sv
// Serialises words into byte-lane transfers (byte_out + byte_sel) for the 8-bit pad path.
// A one-word pending buffer keeps back-to-back words flowing without a bubble.
module data_out_encoder #(
   parameter int NUM_BYTES = data_io_pkg::NUM_BYTES,
   parameter int BYTE_W    = data_io_pkg::BYTE_W,
   parameter bit MSB_FIRST = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic [NUM_BYTES*BYTE_W-1:0]   word_in,
   input  logic                          word_valid,
   output logic                          word_ready,
   output logic [BYTE_W-1:0]             byte_out,
   output logic [$clog2(NUM_BYTES)-1:0]  byte_sel,
   output logic                          byte_valid,
   input  logic                          byte_ready,
   output logic                          byte_last,
   output logic                          busy,
   output logic [CNT_W-1:0]              words_sent
);

   import data_io_pkg::*;

   localparam int WORD_W = NUM_BYTES * BYTE_W;
   localparam int IDX_W  = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(NUM_BYTES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : IDX_W'(NUM_BYTES - 1);

   xfer_state_t       state;
   logic [WORD_W-1:0] shift_reg;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] pend_data;
   logic              pend_full;
   logic              accept;
   logic              byte_xfer;
   logic              last_xfer;
   logic              pend_push;
   logic              pend_pop;

   assign accept    = word_valid && word_ready;
   assign byte_xfer = byte_valid && byte_ready;
   assign last_xfer = byte_xfer && (idx == LAST_IDX);
   // Only words arriving while the current one keeps draining need parking.
   assign pend_push = accept && (state == SEND) && !last_xfer;
   assign pend_pop  = last_xfer && pend_full;

   word_skid_buffer #(
      .WIDTH(WORD_W)
   ) u_pending (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .in_data   (word_in),
      .in_valid  (pend_push),
      .in_ready  (word_ready),
      .out_data  (pend_data),
      .out_valid (pend_full),
      .out_ready (pend_pop)
   );

   assign byte_valid = (state == SEND);
   assign byte_out   = shift_reg[idx*BYTE_W +: BYTE_W];
   assign byte_sel   = idx;
   assign byte_last  = byte_valid && (idx == LAST_IDX);
   assign busy       = byte_valid || pend_full;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         shift_reg  <= '0;
         idx        <= '0;
         words_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shift_reg <= word_in;
                  idx       <= FIRST_IDX;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (byte_xfer) begin
                  if (idx == LAST_IDX) begin
                     words_sent <= words_sent + CNT_W'(1);
                     // Pending word has priority: it was accepted before anything on word_in now.
                     if (pend_full) begin
                        shift_reg <= pend_data;
                        idx       <= FIRST_IDX;
                     end else if (accept) begin
                        shift_reg <= word_in;
                        idx       <= FIRST_IDX;
                     end else begin
                        state <= IDLE;
                     end
                  end else if (MSB_FIRST) begin
                     idx <= idx - IDX_W'(1);
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_out_encoder.sv
// Bench for data_out_encoder: LSB-first and MSB-first instances share stimulus,
// a queue-based byte-stream model plus a behavioural lane decoder checks every transfer.
module tb_data_out_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] word_in = '0;
   logic        word_valid = 1'b0;
   logic        byte_ready = 1'b0;

   logic        word_ready0, word_ready1;
   logic [7:0]  byte_out0, byte_out1;
   logic [1:0]  sel0, sel1;
   logic        bv0, bv1, last0, last1, busy0, busy1;
   logic [15:0] ws0, ws1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_out_encoder #(.NUM_BYTES(4), .BYTE_W(8), .MSB_FIRST(1'b0), .CNT_W(16)) dut_lsb (
      .wb_clk_i(clk), .wb_rst_i(rst), .word_in(word_in), .word_valid(word_valid),
      .word_ready(word_ready0), .byte_out(byte_out0), .byte_sel(sel0), .byte_valid(bv0),
      .byte_ready(byte_ready), .byte_last(last0), .busy(busy0), .words_sent(ws0)
   );

   data_out_encoder #(.NUM_BYTES(4), .BYTE_W(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut_msb (
      .wb_clk_i(clk), .wb_rst_i(rst), .word_in(word_in), .word_valid(word_valid),
      .word_ready(word_ready1), .byte_out(byte_out1), .byte_sel(sel1), .byte_valid(bv1),
      .byte_ready(byte_ready), .byte_last(last1), .busy(busy1), .words_sent(ws1)
   );

   // Behavioural input decoder: writes each received byte into its selected lane.
   logic [31:0] dec0, dec1;
   always @(posedge clk) begin
      if (bv0 && byte_ready) dec0[sel0*8 +: 8] <= byte_out0;
      if (bv1 && byte_ready) dec1[sel1*8 +: 8] <= byte_out1;
   end

   // Reference model: accepted words in order, position within current word, words finished.
   logic [31:0] exp_q[$];
   int          pos = 0;
   int          model_words = 0;
   bit          mon_en = 1'b0;
   bit          stall_prev = 1'b0;
   bit          dec_check = 1'b0;
   logic [31:0] dec_exp;
   logic [31:0] w;
   logic [7:0]  prev_out0, prev_out1;
   logic [1:0]  prev_sel0, prev_sel1;
   logic        prev_last0, prev_last1;

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (ws0 !== 16'(model_words) || ws1 !== 16'(model_words)) begin
            errors++;
            $display("FAIL words_sent: lsb=%0d msb=%0d expected %0d", ws0, ws1, model_words);
         end
         if (dec_check) begin
            checks++;
            if (dec0 !== dec_exp || dec1 !== dec_exp) begin
               errors++;
               $display("FAIL loopback: lsb=%h msb=%h expected %h", dec0, dec1, dec_exp);
            end
            dec_check = 1'b0;
         end
         if (stall_prev) begin
            checks++;
            if (bv0 !== 1'b1 || bv1 !== 1'b1 || byte_out0 !== prev_out0 || byte_out1 !== prev_out1 ||
                sel0 !== prev_sel0 || sel1 !== prev_sel1 || last0 !== prev_last0 || last1 !== prev_last1) begin
               errors++;
               $display("FAIL stall_hold: lsb v=%b %h/%0d msb v=%b %h/%0d expected %h/%0d and %h/%0d held",
                        bv0, byte_out0, sel0, bv1, byte_out1, sel1, prev_out0, prev_sel0, prev_out1, prev_sel1);
            end
         end
         if (rst) begin
            exp_q.delete();
            pos = 0;
            model_words = 0;
            stall_prev = 1'b0;
            dec_check = 1'b0;
         end else begin
            if (bv0 && byte_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL spurious_byte: got %h/%0d with no word outstanding, expected none", byte_out0, sel0);
               end else begin
                  w = exp_q[0];
                  if (bv1 !== 1'b1 ||
                      byte_out0 !== 8'(w >> (8 * pos)) || sel0 !== 2'(pos) || last0 !== (pos == 3) ||
                      byte_out1 !== 8'(w >> (8 * (3 - pos))) || sel1 !== 2'(3 - pos) || last1 !== (pos == 3)) begin
                     errors++;
                     $display("FAIL byte_stream: lsb %h/%0d/%b msb %h/%0d/%b expected %h/%0d/%b and %h/%0d/%b",
                              byte_out0, sel0, last0, byte_out1, sel1, last1,
                              8'(w >> (8 * pos)), pos, pos == 3, 8'(w >> (8 * (3 - pos))), 3 - pos, pos == 3);
                  end
                  if (pos == 3) begin
                     void'(exp_q.pop_front());
                     pos = 0;
                     model_words++;
                     dec_exp = w;
                     dec_check = 1'b1;
                  end else begin
                     pos++;
                  end
               end
            end
            if (word_valid && word_ready0) exp_q.push_back(word_in);
            stall_prev = bv0 && !byte_ready;
            prev_out0 = byte_out0; prev_out1 = byte_out1;
            prev_sel0 = sel0;      prev_sel1 = sel1;
            prev_last0 = last0;    prev_last1 = last1;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      word_valid = 1'b0;
      byte_ready = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      word_valid = 1'b0;
      byte_ready = 1'b0;
      tick;
      tick;
      mon_en = 1'b1;
      @(negedge clk);
      checks++;
      if ({bv0, bv1, last0, last1, busy0, busy1, byte_out0, byte_out1, sel0, sel1} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: v=%b%b last=%b%b busy=%b%b out=%h,%h sel=%0d,%0d expected all 0",
                  bv0, bv1, last0, last1, busy0, busy1, byte_out0, byte_out1, sel0, sel1);
      end
      checks++;
      if (word_ready0 !== 1'b1 || word_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_word_ready: got %b,%b expected 1,1", word_ready0, word_ready1);
      end
      tick;
      rst = 1'b0;
   endtask

   task automatic test_single;
      logic [7:0] exp_l[4];
      exp_l = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      apply_reset;
      word_in = 32'hA1B2C3D4;
      word_valid = 1'b1;
      tick;
      word_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (bv0 !== 1'b1 || byte_out0 !== exp_l[k] || sel0 !== 2'(k) || last0 !== (k == 3)) begin
            errors++;
            $display("FAIL single_lsb[%0d]: v=%b %h/%0d last=%b expected 1 %h/%0d last=%b",
                     k, bv0, byte_out0, sel0, last0, exp_l[k], k, k == 3);
         end
         checks++;
         if (bv1 !== 1'b1 || byte_out1 !== exp_l[3-k] || sel1 !== 2'(3 - k) || last1 !== (k == 3)) begin
            errors++;
            $display("FAIL single_msb[%0d]: v=%b %h/%0d last=%b expected 1 %h/%0d last=%b",
                     k, bv1, byte_out1, sel1, last1, exp_l[3-k], 3 - k, k == 3);
         end
      end
      @(negedge clk);
      checks++;
      if (bv0 !== 1'b0 || bv1 !== 1'b0 || busy0 !== 1'b0 || ws0 !== 16'd1 || ws1 !== 16'd1) begin
         errors++;
         $display("FAIL single_done: v=%b%b busy=%b%b sent=%0d,%0d expected v=00 busy=00 sent=1,1",
                  bv0, bv1, busy0, busy1, ws0, ws1);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] words[2];
      logic        exp_rdy;
      words = '{32'h11223344, 32'h55667788};
      apply_reset;
      word_in = words[0];
      word_valid = 1'b1;
      tick;
      word_in = words[1];
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_rdy = (k == 0 || k >= 4);
         checks++;
         if (bv0 !== 1'b1 || byte_out0 !== 8'(words[k/4] >> (8 * (k % 4))) || sel0 !== 2'(k % 4) ||
             bv1 !== 1'b1 || byte_out1 !== 8'(words[k/4] >> (8 * (3 - k % 4))) || sel1 !== 2'(3 - k % 4)) begin
            errors++;
            $display("FAIL b2b_byte[%0d]: lsb v=%b %h/%0d msb v=%b %h/%0d expected %h/%0d and %h/%0d",
                     k, bv0, byte_out0, sel0, bv1, byte_out1, sel1,
                     8'(words[k/4] >> (8 * (k % 4))), k % 4, 8'(words[k/4] >> (8 * (3 - k % 4))), 3 - k % 4);
         end
         checks++;
         if (word_ready0 !== exp_rdy || word_ready1 !== exp_rdy) begin
            errors++;
            $display("FAIL b2b_word_ready[%0d]: got %b,%b expected %b", k, word_ready0, word_ready1, exp_rdy);
         end
         if (k == 0) begin
            tick;
            word_valid = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if (bv0 !== 1'b0 || ws0 !== 16'd2 || ws1 !== 16'd2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_done: v=%b sent=%0d,%0d queued=%0d expected v=0 sent=2,2 queued=0",
                  bv0, ws0, ws1, exp_q.size());
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] wd;
      int          exp_k[7];
      exp_k = '{0, 1, 1, 1, 1, 2, 3};
      wd = $urandom;
      apply_reset;
      word_in = wd;
      word_valid = 1'b1;
      tick;
      word_valid = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         checks++;
         if (bv0 !== 1'b1 || byte_out0 !== 8'(wd >> (8 * exp_k[c])) || sel0 !== 2'(exp_k[c]) ||
             byte_out1 !== 8'(wd >> (8 * (3 - exp_k[c]))) || sel1 !== 2'(3 - exp_k[c])) begin
            errors++;
            $display("FAIL backpressure[%0d]: lsb v=%b %h/%0d msb %h/%0d expected %h/%0d and %h/%0d",
                     c, bv0, byte_out0, sel0, byte_out1, sel1,
                     8'(wd >> (8 * exp_k[c])), exp_k[c], 8'(wd >> (8 * (3 - exp_k[c]))), 3 - exp_k[c]);
         end
         tick;
         byte_ready = (c > 2);
      end
      @(negedge clk);
      checks++;
      if (bv0 !== 1'b0 || ws0 !== 16'd1 || ws1 !== 16'd1) begin
         errors++;
         $display("FAIL backpressure_done: v=%b sent=%0d,%0d expected v=0 sent=1,1", bv0, ws0, ws1);
      end
   endtask

   task automatic test_reset_mid_word;
      logic [31:0] w1, w2, w3;
      w1 = $urandom;
      w2 = $urandom;
      w3 = $urandom;
      apply_reset;
      word_in = w1;
      word_valid = 1'b1;
      tick;
      word_in = w2;
      tick;
      word_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (word_ready0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL mid_pending_full: word_ready=%b busy=%b expected 0 and 1", word_ready0, busy0);
      end
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      word_in = w3;
      word_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({bv0, bv1, last0, last1, busy0, busy1, byte_out0, byte_out1, sel0, sel1, ws0, ws1} !== '0 ||
          word_ready0 !== 1'b1 || word_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_outputs: v=%b%b busy=%b%b out=%h,%h sel=%0d,%0d sent=%0d rdy=%b expected zeros, rdy=1",
                  bv0, bv1, busy0, busy1, byte_out0, byte_out1, sel0, sel1, ws0, word_ready0);
      end
      tick;
      word_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bv0 !== 1'b1 || sel0 !== 2'd0 || byte_out0 !== w3[7:0] || sel1 !== 2'd3 || byte_out1 !== w3[31:24]) begin
         errors++;
         $display("FAIL mid_restart: lsb v=%b %h/%0d msb %h/%0d expected %h/0 and %h/3",
                  bv0, byte_out0, sel0, byte_out1, sel1, w3[7:0], w3[31:24]);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (bv0 !== 1'b0 || ws0 !== 16'd1 || ws1 !== 16'd1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_done: v=%b sent=%0d,%0d queued=%0d expected v=0 sent=1,1 queued=0",
                  bv0, ws0, ws1, exp_q.size());
      end
   endtask

   task automatic test_loopback;
      int acc = 0;
      int cyc = 0;
      bit took;
      apply_reset;
      while (acc < 100 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         took = word_valid && word_ready0;
         if (took) acc++;
         tick;
         byte_ready = ($urandom_range(0, 3) != 0);
         if (took || !word_valid) begin
            if (acc < 100 && $urandom_range(0, 3) != 0) begin
               word_in = $urandom;
               word_valid = 1'b1;
            end else begin
               word_valid = 1'b0;
            end
         end
      end
      word_valid = 1'b0;
      byte_ready = 1'b1;
      checks++;
      if (acc != 100) begin
         errors++;
         $display("FAIL loopback_accept_timeout: accepted %0d expected 100", acc);
      end
      cyc = 0;
      @(negedge clk);
      while (busy0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL loopback_drain_timeout: busy=%b%b expected 00", busy0, busy1);
      end
      checks++;
      if (ws0 !== 16'd100 || ws1 !== 16'd100 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL loopback_count: sent=%0d,%0d queued=%0d expected 100,100 queued=0",
                  ws0, ws1, exp_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_reset_mid_word;
      test_loopback;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
